uart_tx_arbiter: RTL and testbench

Shares the single 115 200 Bd UART transmitter between N_REQ byte-stream requesters (e.g. counter display, debug echo, status reporter). It grants the transmitter round-robin at message granularity, so a multi-byte message is never interleaved. It latches the granted byte and drives the UART's ipTxData/ipTxSend, following the UART send handshake against opTxBusy. It sits directly in front of the UART TX port in the top level, with the UART's outputs wired back in.

---
 rtl/uart_tx_arbiter.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between N_REQ byte-stream
// requesters. Ownership is granted round-robin per message, so the bytes
// of one message are never interleaved with another requester's bytes.
// The granted byte is latched and driven to the UART using the
// send/busy handshake.
//
// Ports:
//   ipClk, ipReset  clock; synchronous active-high reset
//   ipReqValid[i]   requester i has a byte pending
//   ipReqData       requester i's byte in bits [8i+7:8i]
//   ipReqLast[i]    pending byte is the last of i's message
//   opReqAck[i]     one-cycle pulse: requester i's byte was taken
//   opGrant         one-hot current owner, zero when there is no owner
//   opUartTxData    byte to UART ipTxData
//   opUartTxSend    send request to UART ipTxSend
//   ipUartTxBusy    UART opTxBusy
//   opError         one-cycle pulse: byte dropped, busy never rose
//   opIdle          arbitrating with no owner
module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic               ipClk,
   input  logic               ipReset,
   input  logic [N_REQ-1:0]   ipReqValid,
   input  logic [8*N_REQ-1:0] ipReqData,
   input  logic [N_REQ-1:0]   ipReqLast,
   output logic [N_REQ-1:0]   opReqAck,
   output logic [N_REQ-1:0]   opGrant,
   output logic [7:0]         opUartTxData,
   output logic               opUartTxSend,
   input  logic               ipUartTxBusy,
   output logic               opError,
   output logic               opIdle
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_ARB,
      S_WAIT_FREE,
      S_SEND,
      S_NEXT,
      S_LOCK
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    own_q, own_d;
   logic             last_q, last_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] ack_q, ack_d;
   logic [7:0]       data_q, data_d;
   logic             send_q, send_d;
   logic             err_q, err_d;
   logic             idle_q, idle_d;

   logic             hit;
   logic [IW-1:0]    pick;
   logic [IW-1:0]    scan_idx;

   // First valid requester at or above the pointer, wrapping.
   always_comb begin
      hit      = 1'b0;
      pick     = '0;
      scan_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = IW'((int'(ptr_q) + k) % N_REQ);
         if (!hit && ipReqValid[scan_idx]) begin
            hit  = 1'b1;
            pick = scan_idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      own_d   = own_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      ack_d   = '0;
      data_d  = data_q;
      send_d  = send_q;
      err_d   = 1'b0;
      unique case (state_q)
         S_ARB: begin
            if (hit) begin
               own_d   = pick;
               grant_d = N_REQ'(1) << pick;
               ack_d   = N_REQ'(1) << pick;
               data_d  = ipReqData[{pick, 3'b000} +: 8];
               last_d  = ipReqLast[pick];
               state_d = S_WAIT_FREE;
            end
         end
         S_WAIT_FREE: begin
            if (!ipUartTxBusy) begin
               send_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (ipUartTxBusy) begin
               send_d  = 1'b0;
               state_d = S_NEXT;
            end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
               // UART never took the byte: drop it and move on.
               send_d  = 1'b0;
               err_d   = 1'b1;
               state_d = S_NEXT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_NEXT: begin
            if (last_q) begin
               grant_d = '0;
               ptr_d   = (own_q == IW'(N_REQ - 1)) ?
                         '0 : own_q + 1'b1;
               state_d = S_ARB;
            end else begin
               state_d = S_LOCK;
            end
         end
         S_LOCK: begin
            // Mid-message: only the owner may continue.
            if (ipReqValid[own_q]) begin
               ack_d   = N_REQ'(1) << own_q;
               data_d  = ipReqData[{own_q, 3'b000} +: 8];
               last_d  = ipReqLast[own_q];
               state_d = S_WAIT_FREE;
            end
         end
         default: state_d = S_ARB;
      endcase
      idle_d = (state_d == S_ARB);
   end

   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         state_q <= S_ARB;
         ptr_q   <= '0;
         own_q   <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         data_q  <= '0;
         send_q  <= 1'b0;
         err_q   <= 1'b0;
         idle_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         own_q   <= own_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
         send_q  <= send_d;
         err_q   <= err_d;
         idle_q  <= idle_d;
      end
   end

   assign opReqAck     = ack_q;
   assign opGrant      = grant_q;
   assign opUartTxData = data_q;
   assign opUartTxSend = send_q;
   assign opError      = err_q;
   assign opIdle       = idle_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for uart_tx_arbiter with
// requester queues, a small UART model and a transaction-level checker.
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int TO    = 16;
   localparam int FRAME = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic [N-1:0]   valid;
   logic [8*N-1:0] data;
   logic [N-1:0]   last;
   logic           busy;
   logic [N-1:0]   ack;
   logic [N-1:0]   grant;
   logic [7:0]     txd;
   logic           send;
   logic           err;
   logic           idle;

   uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(TO)) dut (
      .ipClk       (clk),
      .ipReset     (rst),
      .ipReqValid  (valid),
      .ipReqData   (data),
      .ipReqLast   (last),
      .opReqAck    (ack),
      .opGrant     (grant),
      .opUartTxData(txd),
      .opUartTxSend(send),
      .ipUartTxBusy(busy),
      .opError     (err),
      .opIdle      (idle)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Requester byte queues: {last, data}.
   logic [8:0] mem [N][16];
   int         head [N];
   int         tail [N];
   logic [N-1:0] ack_seen;

   // UART model: mode 0 normal, 1 busy stuck low, 2 busy stuck high.
   int         mode;
   logic       ubusy;
   int         bcnt;
   logic [7:0] sent [$];

   task automatic push(input int r, input logic [7:0] b, input logic l);
      mem[r][tail[r] % 16] = {l, b};
      tail[r]++;
   endtask

   function automatic logic all_empty();
      for (int i = 0; i < N; i++)
         if (head[i] != tail[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] sent_at(input int i);
      if (i < sent.size()) return {24'h0, sent[i]};
      return 32'hFFF;
   endfunction

   // Drives requesters and UART busy 2 time units after each edge.
   always @(posedge clk) begin
      #2;
      for (int i = 0; i < N; i++)
         if (ack_seen[i] && head[i] != tail[i]) head[i]++;
      ack_seen = '0;
      case (mode)
         1: begin ubusy = 1'b0; bcnt = 0; end
         2: begin ubusy = 1'b1; bcnt = 0; end
         default: begin
            if (ubusy) begin
               if (bcnt == 0) ubusy = 1'b0;
               else bcnt--;
            end else if (send) begin
               sent.push_back(txd);
               ubusy = 1'b1;
               bcnt  = FRAME;
            end
         end
      endcase
      busy = ubusy;
      for (int i = 0; i < N; i++) begin
         valid[i]       = (head[i] != tail[i]);
         data[8*i +: 8] = mem[i][head[i] % 16][7:0];
         last[i]        = mem[i][head[i] % 16][8];
      end
   end

   function automatic int rr_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++)
         if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   // Transaction-level checker, evaluated every cycle.
   logic         prev_rst = 1'b1;
   logic [N-1:0] prev_valid;
   logic         prev_send;
   logic         prev_busy;
   int           run;
   int           owner;
   int           ptr;
   logic [7:0]   cur_exp;
   logic         cur_last;
   logic         in_wait;
   logic         rel_pend;
   logic         was_wait;
   logic         exp_send;
   logic         exp_err;
   int           exp_i;

   always @(negedge clk) begin
      ack_seen = ack;
      if (prev_rst) begin
         chk("rst_ack", ack, 0);
         chk("rst_grant", grant, 0);
         chk("rst_send", send, 0);
         chk("rst_err", err, 0);
         chk("rst_idle", idle, 1);
         owner = -1; ptr = 0; run = 0;
         in_wait = 1'b0; rel_pend = 1'b0;
         cur_exp = 8'h00; cur_last = 1'b0;
      end else begin
         was_wait = in_wait;
         if (rel_pend) begin
            ptr      = (owner + 1) % N;
            owner    = -1;
            rel_pend = 1'b0;
         end
         if (ack != '0) begin
            exp_i = (owner < 0) ? rr_pick(prev_valid, ptr) : owner;
            chk("ack_who", ack, (exp_i < 0) ? 0 : (1 << exp_i));
            chk("ack_when_free", {was_wait, prev_send}, 0);
            if (exp_i >= 0) begin
               chk("ack_src_valid", prev_valid[exp_i], 1);
               owner    = exp_i;
               cur_exp  = mem[exp_i][head[exp_i] % 16][7:0];
               cur_last = mem[exp_i][head[exp_i] % 16][8];
               in_wait  = 1'b1;
            end
         end
         exp_send = was_wait ? !prev_busy
                             : (prev_send && !prev_busy && run < TO);
         exp_err  = !was_wait && prev_send && !prev_busy && run == TO;
         chk("send", send, exp_send);
         chk("error", err, exp_err);
         if (send) chk("txdata", txd, cur_exp);
         if (was_wait && send) in_wait = 1'b0;
         if (!was_wait && prev_send && !send && cur_last)
            rel_pend = 1'b1;
         chk("grant", grant, (owner < 0) ? 0 : (1 << owner));
         chk("idle", idle, owner < 0);
         chk("ack_max1", $onehot0(ack), 1);
      end
      run        = send ? run + 1 : 0;
      prev_rst   = rst;
      prev_valid = valid;
      prev_send  = send;
      prev_busy  = busy;
   end

   task automatic wait_idle(input string nm);
      int k;
      for (k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (all_empty() && idle && !ubusy) break;
      end
      chk({nm, "_done"}, k < 3000, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < N; i++) head[i] = tail[i];
      sent.delete();
      ubusy = 1'b0; bcnt = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   int cs;
   int ce;
   int k;

   initial begin
      rst = 1'b1; valid = '0; data = '0; last = '0; busy = 1'b0;
      mode = 0; ubusy = 1'b0; bcnt = 0; ack_seen = '0;
      for (int i = 0; i < N; i++) begin
         head[i] = 0; tail[i] = 0;
         for (int j = 0; j < 16; j++) mem[i][j] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_data", txd, 0);
      chk("reset_idle", idle, 1);

      // Single byte from requester 0.
      @(posedge clk); #1;
      push(0, 8'h41, 1'b1);
      @(posedge clk); @(negedge clk);
      chk("t1_ack", ack, 4'b0001);
      chk("t1_grant", grant, 4'b0001);
      @(negedge clk);
      chk("t1_ack_once", ack, 4'b0000);
      wait_idle("t1");
      chk("t1_n", sent.size(), 1);
      chk("t1_b0", sent_at(0), 8'h41);
      chk("t1_grant_rel", grant, 0);
      // Pointer now 1: requester 1 beats requester 0.
      @(posedge clk); #1;
      push(0, 8'h10, 1'b1);
      push(1, 8'h11, 1'b1);
      wait_idle("t1p");
      chk("t1p_b1", sent_at(1), 8'h11);
      chk("t1p_b2", sent_at(2), 8'h10);

      // Contention from pointer 0.
      do_reset();
      push(1, 8'h31, 1'b1);
      push(2, 8'h32, 1'b1);
      wait_idle("t2");
      chk("t2_b0", sent_at(0), 8'h31);
      chk("t2_b1", sent_at(1), 8'h32);
      @(posedge clk); #1;
      push(0, 8'h40, 1'b1);
      push(3, 8'h43, 1'b1);
      wait_idle("t2p");
      chk("t2p_b2", sent_at(2), 8'h43);
      chk("t2p_b3", sent_at(3), 8'h40);

      // Message locking.
      do_reset();
      push(0, 8'h41, 1'b0);
      push(0, 8'h42, 1'b0);
      push(0, 8'h43, 1'b1);
      push(3, 8'h5A, 1'b1);
      wait_idle("t3");
      chk("t3_n", sent.size(), 4);
      chk("t3_b0", sent_at(0), 8'h41);
      chk("t3_b1", sent_at(1), 8'h42);
      chk("t3_b2", sent_at(2), 8'h43);
      chk("t3_b3", sent_at(3), 8'h5A);

      // Handshake against a long busy period.
      do_reset();
      mode = 2;
      push(0, 8'h55, 1'b1);
      cs = 0;
      repeat (100) begin
         @(negedge clk);
         if (send) cs++;
      end
      chk("t4_hold", cs, 0);
      chk("t4_grant", grant, 4'b0001);
      @(posedge clk); #1;
      mode = 0;
      @(negedge clk);
      chk("t4_s0", send, 0);
      @(negedge clk);
      chk("t4_s1", send, 1);
      @(negedge clk);
      chk("t4_s2", send, 0);
      wait_idle("t4");
      chk("t4_b0", sent_at(0), 8'h55);

      // Timeout with busy stuck low.
      do_reset();
      mode = 1;
      push(0, 8'h77, 1'b1);
      cs = 0; ce = 0;
      repeat (40) begin
         @(negedge clk);
         if (send) cs++;
         if (err) ce++;
      end
      chk("t5_send_cycles", cs, TO);
      chk("t5_err_pulses", ce, 1);
      chk("t5_grant", grant, 0);
      chk("t5_idle", idle, 1);
      chk("t5_n", sent.size(), 0);

      // Reset while sending.
      push(1, 8'h99, 1'b1);
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if (send) break;
      end
      chk("t6_send_seen", k < 50, 1);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("t6_send", send, 0);
      chk("t6_grant", grant, 0);
      chk("t6_idle", idle, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      mode = 0;
      push(2, 8'hA2, 1'b1);
      push(0, 8'hA0, 1'b1);
      wait_idle("t6");
      chk("t6_n", sent.size(), 2);
      chk("t6_b0", sent_at(0), 8'hA0);
      chk("t6_b1", sent_at(1), 8'hA2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
